// File: rtl/vga_pixel_out_if.sv
// vga_pixel_out_if: pixel path between the object mux, the raster generator and the VGA pins
interface vga_pixel_out_if;
    logic [7:0]  RGBIn;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        VGA_SYNC_N;

    modport master (
        input  RGBIn,
        output pixelX, pixelY, startOfFrame,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );

    modport slave (
        output RGBIn,
        input  pixelX, pixelY, startOfFrame,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
    );
endinterface

// File: rtl/vga_pixel_out.sv
// vga_pixel_out: raster counters plus sync/blank delayed to meet the mux pixel, expanded to 8-bit DAC colour
module vga_pixel_out #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input logic             clk,
    input logic             resetN,
    vga_pixel_out_if.master vga
);
    localparam logic [10:0] H_TOTAL  = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] V_TOTAL  = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] hcnt, vcnt, h_next, v_next;
    logic h_wrap, hs_raw, vs_raw, vis_raw, sof_next, vis_d;
    logic [PIPE_DELAY-1:0] hs_sr, vs_sr, vis_sr;
    logic [2:0] r, g;
    logic [1:0] b;

    assign vga.pixelX     = hcnt;
    assign vga.pixelY     = vcnt;
    assign vga.VGA_SYNC_N = 1'b0;

    always_comb begin
        h_wrap   = hcnt == H_TOTAL - 11'd1;
        h_next   = h_wrap ? '0 : hcnt + 11'd1;
        v_next   = !h_wrap ? vcnt : (vcnt == V_TOTAL - 11'd1) ? '0 : vcnt + 11'd1;
        sof_next = h_next == '0 && v_next == V_VIS;
        hs_raw   = !(hcnt >= HS_START && hcnt < HS_END);
        vs_raw   = !(vcnt >= VS_START && vcnt < VS_END);
        vis_raw  = hcnt < H_VIS && vcnt < V_VIS;
        vis_d    = vis_sr[PIPE_DELAY-1];
        {r, g, b} = vga.RGBIn;
    end

    // Sync/blank travel PIPE_DELAY stages so the output register pairs them with the RGB that comes back
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hcnt             <= '0;
            vcnt             <= '0;
            vga.startOfFrame <= 1'b0;
            hs_sr            <= '1;
            vs_sr            <= '1;
            vis_sr           <= '0;
            vga.VGA_HS       <= 1'b1;
            vga.VGA_VS       <= 1'b1;
            vga.VGA_BLANK_N  <= 1'b0;
            vga.VGA_R        <= '0;
            vga.VGA_G        <= '0;
            vga.VGA_B        <= '0;
        end else begin
            hcnt             <= h_next;
            vcnt             <= v_next;
            vga.startOfFrame <= sof_next;
            hs_sr            <= PIPE_DELAY'({hs_sr, hs_raw});
            vs_sr            <= PIPE_DELAY'({vs_sr, vs_raw});
            vis_sr           <= PIPE_DELAY'({vis_sr, vis_raw});
            vga.VGA_HS       <= hs_sr[PIPE_DELAY-1];
            vga.VGA_VS       <= vs_sr[PIPE_DELAY-1];
            vga.VGA_BLANK_N  <= vis_d;
            vga.VGA_R        <= vis_d ? {r, r, r[2:1]} : '0;
            vga.VGA_G        <= vis_d ? {g, g, g[2:1]} : '0;
            vga.VGA_B        <= vis_d ? {b, b, b, b} : '0;
        end
    end
endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: lane 0 is the full 640x480 raster, lane 1 a shrunken raster (PIPE_DELAY 3) so whole frames fit the run
module tb_vga_pixel_out;
    typedef struct {
        logic [7:0]  rgb_in;
        logic [23:0] rgb_out;
    } vec_t;

    localparam logic [26:0] IDLE = 27'h6000000;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    vga_pixel_out_if vif0 ();
    vga_pixel_out_if vif1 ();

    vga_pixel_out dut0 (.clk(clk), .resetN(resetN), .vga(vif0));
    vga_pixel_out #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DELAY(3)
    ) dut1 (.clk(clk), .resetN(resetN), .vga(vif1));

    int h_vis[2] = '{640, 16};
    int h_fp[2]  = '{16, 4};
    int h_sw[2]  = '{96, 6};
    int h_tot[2] = '{800, 30};
    int v_vis[2] = '{480, 12};
    int v_fp[2]  = '{10, 2};
    int v_sw[2]  = '{2, 2};
    int v_tot[2] = '{525, 19};
    int pd[2]    = '{2, 3};

    logic [26:0] o[2];
    logic [10:0] px[2], py[2];
    logic        sof[2], sync_n[2];
    assign o[0]      = {vif0.VGA_HS, vif0.VGA_VS, vif0.VGA_BLANK_N, vif0.VGA_R, vif0.VGA_G, vif0.VGA_B};
    assign o[1]      = {vif1.VGA_HS, vif1.VGA_VS, vif1.VGA_BLANK_N, vif1.VGA_R, vif1.VGA_G, vif1.VGA_B};
    assign px[0]     = vif0.pixelX;
    assign px[1]     = vif1.pixelX;
    assign py[0]     = vif0.pixelY;
    assign py[1]     = vif1.pixelY;
    assign sof[0]    = vif0.startOfFrame;
    assign sof[1]    = vif1.startOfFrame;
    assign sync_n[0] = vif0.VGA_SYNC_N;
    assign sync_n[1] = vif1.VGA_SYNC_N;

    vec_t tbl[6];
    logic [53:0] sb[$];
    int t, checks, errors, white0;
    int hs_fall[2], bl_rise[2], vs_fall[2], sof_last[2], n_hs[2], n_sof[2];
    logic prev_hs[2], prev_vs[2], prev_bl[2];

    task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d t=%0d: got %0h expected %0h", name, l, t, act, exp);
        end
    endtask

    // RGBIn the drawing model returns for raster position k (negative k = pipeline fill garbage)
    function automatic int pick(input int l, input int k);
        int xk, yk;
        if (k < 0 || k >= h_tot[l] * v_tot[l]) return 5;
        xk = k % h_tot[l];
        yk = k / h_tot[l];
        if (yk % 6 == 0) return (xk == 0) ? 5 : 2;
        return yk % 6 - 1;
    endfunction

    function automatic logic [26:0] exp_out(input int l, input int k, input logic [23:0] col);
        int x, y;
        logic hs, vs, vis;
        if (k < 0) return IDLE;
        x   = k % h_tot[l];
        y   = (k / h_tot[l]) % v_tot[l];
        hs  = !(x >= h_vis[l] + h_fp[l] && x < h_vis[l] + h_fp[l] + h_sw[l]);
        vs  = !(y >= v_vis[l] + v_fp[l] && y < v_vis[l] + v_fp[l] + v_sw[l]);
        vis = x < h_vis[l] && y < v_vis[l];
        return {hs, vs, vis, vis ? col : 24'h0};
    endfunction

    task automatic check_idle();
        for (int l = 0; l < 2; l++) begin
            chk("idle_out", l, o[l], IDLE);
            chk("idle_pixelX", l, px[l], 0);
            chk("idle_pixelY", l, py[l], 0);
            chk("idle_sof", l, sof[l], 0);
            chk("sync_n", l, sync_n[l], 0);
        end
    endtask

    task automatic step();
        logic [53:0] e, nxt;
        int x, y, k, idx;
        logic hs, vs, bl;
        e = '1;
        nxt = '0;
        chk("sb_level", 0, sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        for (int l = 0; l < 2; l++) begin
            x = t % h_tot[l];
            y = (t / h_tot[l]) % v_tot[l];
            chk("pixelX", l, px[l], x);
            chk("pixelY", l, py[l], y);
            chk("out", l, o[l], e[l*27 +: 27]);
            chk("sof", l, sof[l], x == 0 && y == v_vis[l]);
            hs = o[l][26];
            vs = o[l][25];
            bl = o[l][24];
            if (!bl) chk("blank_black", l, o[l][23:0], 0);
            if (l == 0 && o[0][23:0] == 24'hFFFFFF) white0++;
            if (prev_hs[l] && !hs) begin
                if (hs_fall[l] >= 0) chk("hs_period", l, t - hs_fall[l], h_tot[l]);
                else chk("hs_first", l, t, h_vis[l] + h_fp[l] + pd[l] + 1);
                hs_fall[l] = t;
                n_hs[l]++;
            end
            if (!prev_hs[l] && hs) chk("hs_width", l, t - hs_fall[l], h_sw[l]);
            if (!prev_bl[l] && bl) bl_rise[l] = t;
            if (prev_bl[l] && !bl) chk("blank_run", l, t - bl_rise[l], h_vis[l]);
            if (prev_vs[l] && !vs) vs_fall[l] = t;
            if (!prev_vs[l] && vs) chk("vs_width", l, t - vs_fall[l], v_sw[l] * h_tot[l]);
            if (sof[l]) begin
                if (sof_last[l] >= 0) chk("sof_period", l, t - sof_last[l], h_tot[l] * v_tot[l]);
                sof_last[l] = t;
                n_sof[l]++;
            end
            prev_hs[l] = hs;
            prev_vs[l] = vs;
            prev_bl[l] = bl;
            k   = t - pd[l];
            idx = pick(l, k);
            if (l == 0) vif0.RGBIn = tbl[idx].rgb_in;
            else vif1.RGBIn = tbl[idx].rgb_in;
            nxt[l*27 +: 27] = exp_out(l, k, tbl[idx].rgb_out);
        end
        sb.push_back(nxt);
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetN = 1'b1;
        t = 0;
        white0 = 0;
        sb.delete();
        sb.push_back({IDLE, IDLE});
        for (int l = 0; l < 2; l++) begin
            hs_fall[l]  = -1;
            bl_rise[l]  = -1;
            vs_fall[l]  = -1;
            sof_last[l] = -1;
            n_hs[l]     = 0;
            n_sof[l]    = 0;
            prev_hs[l]  = 1'b1;
            prev_vs[l]  = 1'b1;
            prev_bl[l]  = 1'b0;
        end
        #1 step();
    endtask

    initial begin
        tbl[0] = '{8'hE0, 24'hFF0000};
        tbl[1] = '{8'h6F, 24'h6D6DFF};
        tbl[2] = '{8'h00, 24'h000000};
        tbl[3] = '{8'h92, 24'h9292AA};
        tbl[4] = '{8'h1C, 24'h00FF00};
        tbl[5] = '{8'hFF, 24'hFFFFFF};
        checks = 0;
        errors = 0;
        white0 = 0;
        t = 0;
        resetN = 1'b0;
        vif0.RGBIn = 8'h00;
        vif1.RGBIn = 8'h00;
        repeat (5) @(posedge clk);
        #1 check_idle();
        release_reset();
        repeat (3040) begin
            @(posedge clk);
            #1 t++;
            step();
        end
        chk("white_px", 0, white0, 1);
        chk("n_hs", 0, n_hs[0], 3);
        chk("n_sof", 1, n_sof[1], 5);
        // lane 1 is now mid-frame at pixelY=6: reset must idle everything at once
        resetN = 1'b0;
        #1 check_idle();
        repeat (3) @(posedge clk);
        #1 check_idle();
        release_reset();
        repeat (700) begin
            @(posedge clk);
            #1 t++;
            step();
        end
        chk("white_px_restart", 0, white0, 1);
        chk("n_hs_restart", 0, n_hs[0], 1);
        chk("n_sof_restart", 1, n_sof[1], 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pixel_out.md
# vga_pixel_out

Display-side end of the object-mux pixel path: generates the 640x480@60 Hz raster counters that every drawing object and the object mux consume, and receives the mux's registered 8-bit RRRGGGBB pixel stream for output to the board DAC. It delays sync and blanking by the depth of the drawing pipeline so they line up with the RGB that comes back. It expands RGB to 8 bits per channel and forces black outside the visible area. It sits between the object mux and the VGA connector pins; `clk` is the 25.175/25 MHz pixel clock.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BACK, 33, vertical back porch
- PIPE_DELAY, 2, clk cycles from pixelX/pixelY to the matching RGBIn (object logic plus mux register); legal range 1..8

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- RGBIn  in  8  pixel from object mux, {R[2:0],G[2:0],B[1:0]}
- pixelX  out  11  current horizontal count, 0..H_total-1
- pixelY  out  11  current vertical count, 0..V_total-1
- startOfFrame  out  1  one-cycle pulse at start of vertical blanking
- VGA_R / VGA_G / VGA_B  out  8 each  expanded colour
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_SYNC_N  out  1  tied 0

## Operation
- H_total = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_total is the same sum for the vertical parameters (525).
- hCnt increments every clk and wraps at H_total-1 to 0. vCnt increments when hCnt wraps and wraps at V_total-1 to 0. pixelX = hCnt and pixelY = vCnt; both are registered.
- Raw per-cycle signals are derived from the current counters:
  - hs_raw = 0 for H_VISIBLE+H_FRONT ≤ hCnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw = 0 for 490 ≤ vCnt < 492 (same formula, vertical).
  - vis_raw = (hCnt < H_VISIBLE) && (vCnt < V_VISIBLE).
- hs_raw, vs_raw and vis_raw pass through a PIPE_DELAY-deep shift register, then one output register.
- RGB is expanded in the output register:
  - R8 = {R,R,R[2:1]}, G8 = {G,G,G[2:1]}, B8 = {B,B,B,B}.
  - If the delayed vis = 0, VGA_R, VGA_G and VGA_B are 0.
- VGA_BLANK_N = delayed vis.
- startOfFrame is registered high for exactly one cycle when hCnt==0 && vCnt==V_VISIBLE. It is not delayed, so game logic gets the full blanking interval.
- Counters never saturate; wrap-around is the only boundary. Parameters are constants, so no runtime reconfiguration exists.

## Timing
- Reset values (async, resetN=0):
  - pixelX=0, pixelY=0, startOfFrame=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB outputs=0.
  - All shift-register stages hold the idle pattern (hs=1, vs=1, vis=0).
- First rising edge after release: counters go to hCnt=1, vCnt=0. The first cycle after release presents pixelX=0, pixelY=0.
- Alignment invariant: outputs at cycle t (VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R/G/B) all belong to the counter value pixelX/pixelY at cycle t-(PIPE_DELAY+1). RGBIn sampled at t-1 belongs to the counter at t-1-PIPE_DELAY.
- Frame period is exactly H_total*V_total = 420000 clk. Line period is 800 clk.
- Reset asserted mid-line: all outputs return to reset values immediately. The raster restarts at (0,0) with no partial-frame startOfFrame pulse. Delayed-pipeline garbage is discarded because the shift register is reset to idle.
- A startOfFrame pulse and a counter wrap never coincide (480 ≠ 0).

## Test plan
- Reset/release: hold resetN=0 for 5 clk. Require HS=VS=1, BLANK_N=0, RGB=0, pixelX=pixelY=0. After release, pixelX counts 0,1,2,…, and the first HS low appears when pixelX was 656, i.e. PIPE_DELAY+1=3 clk later.
- Horizontal timing: measure over one line. Require the HS low width to be 96 clk, the HS period 800 clk, and BLANK_N high for exactly 640 consecutive clk per visible line.
- Vertical timing and frame pulse: run 2 frames. Require a VS low width of 2 lines (1600 clk), startOfFrame pulses exactly 420000 clk apart, each 1 clk wide, coinciding with pixelX=0, pixelY=480.
- Colour expansion: drive RGBIn=8'hE0 while visible. Require R=FF, G=00, B=00. Drive 8'h6F; require R=6D, G=6D, B=FF. Drive 8'h00; require all 0.
- Pipeline alignment: a model returns RGBIn=8'hFF only for pixelX==0 (delayed 2 clk). Require exactly one white output pixel per line, on the first cycle of BLANK_N high.
- Blanking and mid-frame reset: hold RGBIn=8'hFF constantly. Require RGB=0 whenever BLANK_N=0. Pulse resetN low at pixelY=200; require an immediate idle state, a restart at (0,0), and no spurious startOfFrame.
